// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with a 2-bit saturating counter per entry.
// Latency: lookup is combinational (0 cycles); a resolution write is visible on the next cycle.
// Backpressure: none; a resolution record is accepted every cycle that write is high.
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] write_key,
    input  logic [ADDR_WIDTH-1:0] write_val,
    input  logic                  hit,
    input  logic [ADDR_WIDTH-1:0] read_key,
    output logic [ADDR_WIDTH-1:0] read_val,
    output logic                  read_valid
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS;

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    localparam logic [1:0] CTR_WEAK_T = 2'b10;
    localparam logic [1:0] CTR_MAX    = 2'b11;
    localparam logic [1:0] CTR_MIN    = 2'b00;

    logic                  valid_q  [ENTRIES];
    logic                  valid_d  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [TAG_W-1:0]      tag_d    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [1:0]            ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] r_idx;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_match;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_match;

    // Same-cycle lookup of the fetch PC against the current (pre-update) table contents.
    always_comb begin
        r_idx      = read_key[INDEX_BITS-1:0];
        r_tag      = read_key[ADDR_WIDTH-1:INDEX_BITS];
        r_match    = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
        read_valid = r_match && ctr_q[r_idx][1] && !reset;
        read_val   = read_valid ? target_q[r_idx] : '0;
    end

    // Next-state for the table: only the entry selected by write_key can change.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        w_idx   = write_key[INDEX_BITS-1:0];
        w_tag   = write_key[ADDR_WIDTH-1:INDEX_BITS];
        w_match = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
        if (write) begin
            if (w_match) begin
                if (hit) begin
                    if (ctr_q[w_idx] != CTR_MAX) begin
                        ctr_d[w_idx] = ctr_q[w_idx] + 2'd1;
                    end
                    target_d[w_idx] = write_val;
                end else if (ctr_q[w_idx] != CTR_MIN) begin
                    // Not-taken on a resident branch only weakens it; target kept.
                    ctr_d[w_idx] = ctr_q[w_idx] - 2'd1;
                end
            end else if (hit) begin
                // Taken branch not resident: allocate or evict the aliasing entry.
                valid_d[w_idx]  = 1'b1;
                tag_d[w_idx]    = w_tag;
                target_d[w_idx] = write_val;
                ctr_d[w_idx]    = CTR_WEAK_T;
            end
            // Not-taken and not resident: never allocate, never evict.
        end
    end

    // Table state; reset clears every entry immediately and drops any coincident write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed plan sequences followed by random traffic.
// Expected lookups come from a keyed reference table and are queued at issue time.
// A negedge monitor pops and compares each queued expectation against the outputs.
module tb_branch_target_buffer;

    logic        clk;
    logic        reset;
    logic        write;
    logic [15:0] write_key;
    logic [15:0] write_val;
    logic        hit;
    logic [15:0] read_key;
    logic [15:0] read_val;
    logic        read_valid;

    branch_target_buffer #(.ADDR_WIDTH(16), .INDEX_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .write_key  (write_key),
        .write_val  (write_val),
        .hit        (hit),
        .read_key   (read_key),
        .read_val   (read_val),
        .read_valid (read_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [15:0] val;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    bit   chk_en;
    int   total;
    int   bad;

    // Reference: each slot remembers the full PC that owns it and a strength 0..3.
    bit          m_vld [16];
    logic [15:0] m_key [16];
    logic [15:0] m_tgt [16];
    int          m_str [16];

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) begin
            m_vld[i] = 0;
            m_key[i] = '0;
            m_tgt[i] = '0;
            m_str[i] = 0;
        end
    endfunction

    function automatic void m_lookup(input logic [15:0] k, output bit v, output logic [15:0] t);
        int s;
        s = int'(k % 16);
        v = 0;
        t = '0;
        if (m_vld[s] && m_key[s] == k && m_str[s] >= 2) begin
            v = 1;
            t = m_tgt[s];
        end
    endfunction

    function automatic void m_update(input logic [15:0] k, input logic [15:0] v, input bit h);
        int s;
        s = int'(k % 16);
        if (m_vld[s] && m_key[s] == k) begin
            if (h) begin
                m_str[s] = (m_str[s] == 3) ? 3 : m_str[s] + 1;
                m_tgt[s] = v;
            end else begin
                m_str[s] = (m_str[s] == 0) ? 0 : m_str[s] - 1;
            end
        end else if (h) begin
            m_vld[s] = 1;
            m_key[s] = k;
            m_tgt[s] = v;
            m_str[s] = 2;
        end
    endfunction

    task automatic expect_read(input string nm);
        exp_t e;
        m_lookup(read_key, e.v, e.val);
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs, queue the expected lookup, then advance the model on the edge.
    task automatic step(input bit wr, input logic [15:0] wk, input logic [15:0] wv,
                        input bit h, input logic [15:0] rk, input string nm);
        write     = wr;
        write_key = wk;
        write_val = wv;
        hit       = h;
        read_key  = rk;
        expect_read(nm);
        chk_en = 1;
        @(posedge clk);
        if (wr && !reset) m_update(wk, wv, h);
        #1;
    endtask

    task automatic rd(input logic [15:0] rk, input string nm);
        step(0, 16'h0, 16'h0, 0, rk, nm);
    endtask

    // Monitor: compares outputs against the oldest queued expectation each checked cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor_underflow: no expectation queued, read_valid=%0b read_val=%h",
                         read_valid, read_val);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (read_valid !== e.v || read_val !== e.val) begin
                    bad++;
                    $display("FAIL %s: key=%h got valid=%0b val=%h, expected valid=%0b val=%h",
                             e.nm, read_key, read_valid, read_val, e.v, e.val);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] k;
        logic [15:0] rk;
        chk_en    = 0;
        total     = 0;
        bad       = 0;
        reset     = 1;
        write     = 0;
        write_key = '0;
        write_val = '0;
        hit       = 0;
        read_key  = '0;
        m_clear();

        // Reset held: outputs forced low, coincident write discarded.
        @(posedge clk);
        #1;
        step(1, 16'h0012, 16'h0040, 1, 16'h0012, "reset_held");
        reset = 0;

        // Empty table after release.
        for (int i = 0; i < 256; i++) rd(16'(i), "empty_sweep");

        // Allocate with same-cycle read (read-before-write), then visible next cycle.
        step(1, 16'h0012, 16'h0040, 1, 16'h0012, "alloc_same_cycle");
        rd(16'h0012, "alloc_next");

        // Hysteresis.
        step(1, 16'h0012, 16'h0000, 0, 16'h0012, "hyst_nt_same");
        rd(16'h0012, "hyst_weak_nt");
        step(1, 16'h0012, 16'h0050, 1, 16'h0012, "hyst_t_same");
        rd(16'h0012, "hyst_retarget");
        for (int i = 0; i < 3; i++) step(1, 16'h0012, 16'h0050, 1, 16'h0012, "hyst_t_more");
        step(1, 16'h0012, 16'h0000, 0, 16'h0012, "hyst_strong_nt");
        rd(16'h0012, "hyst_still_taken");

        // Saturation low.
        for (int i = 0; i < 4; i++) step(1, 16'h0012, 16'h0000, 0, 16'h0012, "sat_low_nt");
        rd(16'h0012, "sat_low_floor");
        step(1, 16'h0012, 16'h0060, 1, 16'h0012, "sat_low_t1");
        rd(16'h0012, "sat_low_weak_nt");
        step(1, 16'h0012, 16'h0070, 1, 16'h0012, "sat_low_t2");
        rd(16'h0012, "sat_low_recovered");

        // Aliasing: bring 0x0012 to strong-taken, then contend with 0x0112.
        for (int i = 0; i < 3; i++) step(1, 16'h0012, 16'h0070, 1, 16'h0012, "alias_prep");
        step(1, 16'h0112, 16'h0000, 0, 16'h0112, "alias_nt_nonres");
        rd(16'h0012, "alias_resident_kept");
        rd(16'h0112, "alias_nonres_miss");
        step(1, 16'h0112, 16'h0200, 1, 16'h0012, "alias_evict_same");
        rd(16'h0012, "alias_evicted");
        rd(16'h0112, "alias_new_owner");

        // Fill all 16 entries.
        for (int i = 0; i < 16; i++) step(1, 16'h0300 + 16'(i), 16'h1000 + 16'(i), 1, 16'h0300 + 16'(i), "fill");
        for (int i = 0; i < 16; i++) rd(16'h0300 + 16'(i), "fill_check");

        // Async reset pulsed between edges with a write pending.
        write     = 1;
        write_key = 16'h0405;
        write_val = 16'h0abc;
        hit       = 1;
        read_key  = 16'h0307;
        m_clear();
        expect_read("async_reset_immediate");
        chk_en = 1;
        #1 reset = 1;
        @(posedge clk);
        #1;
        write = 0;
        expect_read("async_reset_held");
        #1 reset = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) rd(16'h0300 + 16'(i), "post_reset_empty");
        rd(16'h0405, "post_reset_no_write");
        rd(16'h0012, "post_reset_alias_gone");
        rd(16'h0112, "post_reset_owner_gone");

        // Random traffic over a small key space to exercise hits, aliasing and saturation.
        for (int n = 0; n < 500; n++) begin
            k  = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            rk = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rk = k;
            step(($urandom_range(0, 99) < 70), k, 16'($urandom),
                 ($urandom_range(0, 99) < 60), rk, "random");
        end

        chk_en = 0;
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-side branch target buffer answering the branch unit's resolution traffic. The EX-stage branch unit writes one resolution record per conditional branch or register jump (key = branch PC, value = resolved target, hit = taken). Each cycle, this block returns a same-cycle taken/target prediction for the fetch PC. Direct-mapped, tagged, with one 2-bit saturating counter per entry.

## Interface
- ADDR_WIDTH, 16: width of PCs and targets; matches `ADDR_WIDTH`.
- INDEX_BITS, 4: log2 of entry count; ENTRIES = 2^INDEX_BITS; must be ≥1 and < ADDR_WIDTH.

- clk  in  1  core clock; all updates on rising edge.
- reset  in  1  asynchronous, active-high; clears the table.
- write  in  1  resolution record valid this cycle (branch in EX).
- write_key  in  ADDR_WIDTH  PC of the resolving branch.
- write_val  in  ADDR_WIDTH  resolved jump target.
- hit  in  1  branch resolved taken.
- read_key  in  ADDR_WIDTH  current fetch PC.
- read_val  out  ADDR_WIDTH  predicted target; 0 when read_valid=0.
- read_valid  out  1  predict taken to read_val.

## Operation
- Entry fields: valid (1), tag (ADDR_WIDTH-INDEX_BITS = key[ADDR_WIDTH-1:INDEX_BITS]), target (ADDR_WIDTH), ctr (2-bit saturating; 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Index = key[INDEX_BITS-1:0] for both read and write.
- Lookup (combinational): match = valid & (tag == read_key tag). read_valid = match & ctr[1]. read_val = target when read_valid, else 0.
- Update, on rising clk when write=1 (no effect when write=0):
  - Tag match, hit=1: ctr = min(ctr+1, 3); target = write_val.
  - Tag match, hit=0: ctr = max(ctr-1, 0); target unchanged; entry stays valid.
  - No match (invalid, or different tag), hit=1: allocate/replace. valid=1, tag=write_key tag, target=write_val, ctr=10.
  - No match, hit=0: no change; no allocation on not-taken.
- Only the indexed entry changes; all other entries hold.
- Reset: all valid=0, ctr=00, tag=0, target=0. This takes effect immediately and asynchronously, without waiting for a clock.

## Timing
- Lookup latency 0: read_valid/read_val depend only on read_key and current state in the same cycle.
- Update latency 1: a write in cycle N is visible to lookups in cycle N+1.
- Simultaneous read and write to the same index in one cycle: the lookup returns the pre-update contents (read-before-write).
- Reset asserted mid-operation: outputs drop to read_valid=0, read_val=0 while reset is high. A write pending on the same edge is discarded. First update is accepted on the first rising edge after reset deasserts.
- Output values during reset and after reset: read_valid=0, read_val=0 for every read_key until an allocating write.
- Saturation: ctr never wraps; 11+taken stays 11, 00+not-taken stays 00.
- Aliasing: two PCs with equal index but different tags evict each other. A not-taken record for a non-resident PC never evicts the resident entry.

## Test plan
- Reset/empty: assert reset, release, sweep read_key 0x0000–0x00FF -> read_valid=0, read_val=0 for all.
- Allocate: write=1, write_key=0x0012, write_val=0x0040, hit=1; next cycle read_key=0x0012 -> read_valid=1, read_val=0x0040 (ctr=10). Same-cycle read of 0x0012 during the write -> read_valid=0.
- Hysteresis: starting from the state above, send one not-taken record for 0x0012 -> read_valid=0 (ctr=01). Send one taken record with write_val=0x0050 -> read_valid=1, read_val=0x0050. Send three more taken, then one not-taken -> still read_valid=1 (ctr 11→10).
- Saturation low: drive four not-taken records for 0x0012 -> read_valid=0. Then one taken -> read_valid=0 (ctr 00→01). A second taken -> read_valid=1.
- Aliasing: 0x0012 resident with ctr=11. Send not-taken for 0x0112 -> 0x0012 still predicts. Send taken for 0x0112, write_val=0x0200 -> 0x0012 read_valid=0; 0x0112 read_valid=1, read_val=0x0200.
- Async reset mid-run: after filling 16 entries, pulse reset between clock edges while write=1 -> read_valid=0 immediately. The table stays empty after release, and the write coincident with reset is not recorded.
